// File: rtl/ov7670_pwr_seq.sv
// Power-up sequencer for the OV7670 camera: PWDN / RESET# pin timing, xclk enable,
// SCCB loader kick-off with timeout supervision, retry and ready/fault reporting.
module ov7670_pwr_seq #(
    parameter int PWDN_CYC        = 1000,
    parameter int RST_CYC         = 1000,
    parameter int SETTLE_CYC      = 24000,
    parameter int CFG_TIMEOUT_CYC = 2400000,
    parameter int MAX_RETRY       = 3,
    localparam int RETRY_W        = $clog2(MAX_RETRY + 1) + 1
) (
    input  logic               cam_clk,
    input  logic               resetn,
    input  logic               restart,
    input  logic               cfg_done,
    output logic               cam_clk_en,
    output logic               cam_pwdn,
    output logic               cam_rst_n,
    output logic               cfg_start,
    output logic               ready,
    output logic               fault,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [2:0]         state
);

    localparam int MAX_AB  = (PWDN_CYC > RST_CYC) ? PWDN_CYC : RST_CYC;
    localparam int MAX_CD  = (SETTLE_CYC > CFG_TIMEOUT_CYC) ? SETTLE_CYC : CFG_TIMEOUT_CYC;
    localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0]   PWDN_LAST   = CNT_W'(PWDN_CYC - 1);
    localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_CYC - 1);
    localparam logic [CNT_W-1:0]   SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0]   CFG_LAST    = CNT_W'(CFG_TIMEOUT_CYC - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_PWDN   = 3'd0,
        S_CLKON  = 3'd1,
        S_SETTLE = 3'd2,
        S_CFG    = 3'd3,
        S_READY  = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_d;
    logic               clk_en_d, pwdn_d, rst_n_d, start_d, ready_d, fault_d;
    logic [1:0]         sync_q;
    logic               run;

    // Reset release is brought into the cam_clk domain before the FSM may advance.
    always_ff @(posedge cam_clk or negedge resetn) begin
        if (!resetn) sync_q <= 2'b00;
        else         sync_q <= {sync_q[0], 1'b1};
    end

    assign run = sync_q[1];

    always_comb begin
        // NOTE: every variable gets a default before the case so no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        retry_d = retry_cnt;
        case (state_q)
            S_PWDN:   if (cnt_q == PWDN_LAST)   state_d = S_CLKON;
            S_CLKON:  if (cnt_q == RST_LAST)    state_d = S_SETTLE;
            S_SETTLE: if (cnt_q == SETTLE_LAST) state_d = S_CFG;
            S_CFG: begin
                if (cfg_done) begin
                    state_d = S_READY;
                end else if (cnt_q == CFG_LAST) begin
                    if (retry_cnt < RETRY_MAX) begin
                        state_d = S_PWDN;
                        retry_d = retry_cnt + RETRY_W'(1);
                    end else begin
                        state_d = S_FAULT;
                    end
                end
            end
            S_READY, S_FAULT: begin
                cnt_d = cnt_q;
                if (restart) begin
                    state_d = S_PWDN;
                    retry_d = '0;
                end
            end
            default: state_d = S_PWDN;
        endcase
        if (state_d != state_q) cnt_d = '0;

        // Pins are decoded from the next state so they switch on the transition edge.
        clk_en_d = state_d inside {S_CLKON, S_SETTLE, S_CFG, S_READY};
        pwdn_d   = state_d inside {S_PWDN, S_FAULT};
        rst_n_d  = state_d inside {S_SETTLE, S_CFG, S_READY};
        start_d  = (state_d == S_CFG) && (state_q != S_CFG);
        ready_d  = (state_d == S_READY);
        fault_d  = (state_d == S_FAULT);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge cam_clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_PWDN;
            cnt_q      <= '0;
            retry_cnt  <= '0;
            cam_clk_en <= 1'b0;
            cam_pwdn   <= 1'b1;
            cam_rst_n  <= 1'b0;
            cfg_start  <= 1'b0;
            ready      <= 1'b0;
            fault      <= 1'b0;
        end else if (run) begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            retry_cnt  <= retry_d;
            cam_clk_en <= clk_en_d;
            cam_pwdn   <= pwdn_d;
            cam_rst_n  <= rst_n_d;
            cfg_start  <= start_d;
            ready      <= ready_d;
            fault      <= fault_d;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_ov7670_pwr_seq.sv
// Bench for ov7670_pwr_seq: phase tables expanded into a per-cycle scoreboard,
// plus hand-written reset-abort and reset-release sequences.
module tb_ov7670_pwr_seq;

    localparam logic [2:0] ST_PWDN   = 3'd0;
    localparam logic [2:0] ST_CLKON  = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_CFG    = 3'd3;
    localparam logic [2:0] ST_READY  = 3'd4;
    localparam logic [2:0] ST_FAULT  = 3'd5;

    logic       cam_clk = 1'b0;
    logic       resetn;
    logic       restart;
    logic       cfg_done;
    logic       cam_clk_en, cam_pwdn, cam_rst_n, cfg_start, ready, fault;
    logic [2:0] retry_cnt;
    logic [2:0] state;

    int n_tests = 0;
    int n_fail  = 0;

    ov7670_pwr_seq #(
        .PWDN_CYC(4), .RST_CYC(8), .SETTLE_CYC(16), .CFG_TIMEOUT_CYC(32), .MAX_RETRY(2)
    ) dut (
        .cam_clk(cam_clk), .resetn(resetn), .restart(restart), .cfg_done(cfg_done),
        .cam_clk_en(cam_clk_en), .cam_pwdn(cam_pwdn), .cam_rst_n(cam_rst_n),
        .cfg_start(cfg_start), .ready(ready), .fault(fault),
        .retry_cnt(retry_cnt), .state(state)
    );

    always #5 cam_clk = ~cam_clk;

    typedef struct {
        logic [2:0] st;
        int         n;
        logic       rs;
        logic       dn;
        logic [2:0] rc;
        logic       first;
        string      tag;
    } phase_t;

    typedef struct {
        logic        rs;
        logic        dn;
        logic [11:0] exp;
        string       tag;
    } vec_t;

    phase_t tbl[$];
    vec_t   sb[$];

    function automatic logic [11:0] exp_of(input logic [2:0] st, input logic first,
                                           input logic [2:0] rc);
        logic ce, pd, rn;
        case (st)
            ST_PWDN:   {ce, pd, rn} = 3'b010;
            ST_CLKON:  {ce, pd, rn} = 3'b100;
            ST_SETTLE: {ce, pd, rn} = 3'b101;
            ST_CFG:    {ce, pd, rn} = 3'b101;
            ST_READY:  {ce, pd, rn} = 3'b101;
            default:   {ce, pd, rn} = 3'b010;
        endcase
        return {st, ce, pd, rn, first, st == ST_READY, st == ST_FAULT, rc};
    endfunction

    function automatic logic [11:0] actual();
        return {state, cam_clk_en, cam_pwdn, cam_rst_n, cfg_start, ready, fault, retry_cnt};
    endfunction

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge cam_clk);
        #1;
    endtask

    task automatic add(input logic [2:0] st, input int n, input logic rs, input logic dn,
                       input logic [2:0] rc, input logic first, input string tag);
        phase_t p;
        p.st = st; p.n = n; p.rs = rs; p.dn = dn; p.rc = rc; p.first = first; p.tag = tag;
        tbl.push_back(p);
    endtask

    // Expand the phase table into per-cycle expectations, then replay it against the DUT.
    task automatic run_table();
        vec_t v;
        foreach (tbl[k]) begin
            for (int i = 0; i < tbl[k].n; i++) begin
                v.rs  = tbl[k].rs;
                v.dn  = tbl[k].dn;
                v.exp = exp_of(tbl[k].st, tbl[k].first && (i == 0), tbl[k].rc);
                v.tag = $sformatf("%s[%0d]", tbl[k].tag, i);
                sb.push_back(v);
            end
        end
        tbl.delete();
        while (sb.size() > 0) begin
            v = sb.pop_front();
            check(v.tag, actual(), v.exp);
            restart  = v.rs;
            cfg_done = v.dn;
            tick();
        end
        restart  = 1'b0;
        cfg_done = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] st, input int budget, input string name);
        int k;
        int stray;
        k = 0;
        stray = 0;
        while (state !== st && k < budget) begin
            if (cfg_start === 1'b1) stray++;
            tick();
            k++;
        end
        check({name, " reached"}, {11'd0, state === st}, 12'd1);
        check({name, " no cfg_start"}, 12'(stray), 12'd0);
    endtask

    initial begin
        resetn   = 1'b1;
        restart  = 1'b0;
        cfg_done = 1'b0;
        #1 resetn = 1'b0;
        #1 check("reset async", actual(), exp_of(ST_PWDN, 1'b0, 3'd0));
        tick();
        tick();
        check("reset held", actual(), exp_of(ST_PWDN, 1'b0, 3'd0));
        cfg_done = 1'b1;
        restart  = 1'b1;
        resetn   = 1'b1;
        tick();
        cfg_done = 1'b0;
        restart  = 1'b0;
        wait_state(ST_CLKON, 20, "release");

        // Nominal bring-up, cfg_done five cycles after cfg_start.
        add(ST_CLKON,  8, 0, 0, 0, 0, "t1_clkon");
        add(ST_SETTLE, 16, 0, 0, 0, 0, "t1_settle");
        add(ST_CFG,    1, 0, 0, 0, 1, "t1_start");
        add(ST_CFG,    4, 0, 0, 0, 0, "t1_cfg");
        add(ST_CFG,    1, 0, 1, 0, 0, "t1_done");
        add(ST_READY,  2, 0, 0, 0, 0, "t1_ready");
        // Restart from READY; spurious cfg_done and ignored restarts; then timeouts to FAULT.
        add(ST_READY,  1, 1, 0, 0, 0, "t4_restart");
        add(ST_PWDN,   4, 0, 1, 0, 0, "t6_pwdn");
        add(ST_CLKON,  8, 0, 1, 0, 0, "t6_clkon");
        add(ST_SETTLE, 8, 1, 1, 0, 0, "t6_settle");
        add(ST_SETTLE, 8, 1, 0, 0, 0, "t4_settle");
        add(ST_CFG,    1, 1, 0, 0, 1, "t2_start0");
        add(ST_CFG,    31, 1, 0, 0, 0, "t2_wait0");
        for (int r = 1; r <= 2; r++) begin
            add(ST_PWDN,   4, 0, 0, 3'(r), 0, $sformatf("t2_pwdn%0d", r));
            add(ST_CLKON,  8, 0, 0, 3'(r), 0, $sformatf("t2_clkon%0d", r));
            add(ST_SETTLE, 16, 0, 0, 3'(r), 0, $sformatf("t2_settle%0d", r));
            add(ST_CFG,    1, 0, 0, 3'(r), 1, $sformatf("t2_start%0d", r));
            add(ST_CFG,    31, 0, 0, 3'(r), 0, $sformatf("t2_wait%0d", r));
        end
        add(ST_FAULT,  2, 0, 0, 2, 0, "t2_fault");
        add(ST_FAULT,  1, 1, 1, 2, 0, "t2_fault_restart");
        // One timeout, then cfg_done landing on the timeout cycle.
        add(ST_PWDN,   4, 0, 0, 0, 0, "t3_pwdn0");
        add(ST_CLKON,  8, 0, 0, 0, 0, "t3_clkon0");
        add(ST_SETTLE, 16, 0, 0, 0, 0, "t3_settle0");
        add(ST_CFG,    1, 0, 0, 0, 1, "t3_start0");
        add(ST_CFG,    31, 0, 0, 0, 0, "t3_wait0");
        add(ST_PWDN,   4, 0, 0, 1, 0, "t3_pwdn1");
        add(ST_CLKON,  8, 0, 0, 1, 0, "t3_clkon1");
        add(ST_SETTLE, 16, 0, 0, 1, 0, "t3_settle1");
        add(ST_CFG,    1, 0, 0, 1, 1, "t3_start1");
        add(ST_CFG,    30, 0, 0, 1, 0, "t3_wait1");
        add(ST_CFG,    1, 0, 1, 1, 0, "t3_done_at_timeout");
        add(ST_READY,  2, 0, 0, 1, 0, "t3_ready");
        // Lead-in for the mid-CFG reset abort.
        add(ST_READY,  1, 1, 0, 1, 0, "t5_restart");
        add(ST_PWDN,   4, 0, 0, 0, 0, "t5_pwdn");
        add(ST_CLKON,  8, 0, 0, 0, 0, "t5_clkon");
        add(ST_SETTLE, 16, 0, 0, 0, 0, "t5_settle");
        add(ST_CFG,    1, 0, 0, 0, 1, "t5_start");
        add(ST_CFG,    9, 0, 0, 0, 0, "t5_cfg");
        run_table();

        // One-cycle reset pulse in the middle of CFG.
        resetn = 1'b0;
        #1 check("t5 abort async", actual(), exp_of(ST_PWDN, 1'b0, 3'd0));
        tick();
        check("t5 abort held", actual(), exp_of(ST_PWDN, 1'b0, 3'd0));
        resetn = 1'b1;
        wait_state(ST_CLKON, 20, "t5 release");
        add(ST_CLKON,  8, 0, 0, 0, 0, "t5_re_clkon");
        add(ST_SETTLE, 16, 0, 0, 0, 0, "t5_re_settle");
        add(ST_CFG,    1, 0, 1, 0, 1, "t5_done_on_start");
        add(ST_READY,  3, 0, 0, 0, 0, "t5_ready");
        run_table();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
